// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory and holds the core in reset until it is loaded.
// Optional checksum stage after the last word: define IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps

module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERR
  } state_t;

  localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

  state_t              state;
  logic [1:0]          byte_cnt;
  logic [ADDR_WIDTH:0] idx;
  logic [31:0]         count;
  logic [23:0]         wbuf;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  logic        accept;
  logic [31:0] len_word;
  logic [31:0] idx_next;

  always_comb begin
    rx_ready = (state == LEN) || (state == DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state == CHECK) rx_ready = 1'b1;
`endif
  end

  assign accept   = rx_valid && rx_ready;
  assign len_word = {rx_data, count[31:8]};
  assign idx_next = 32'(idx) + 32'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      idx        <= '0;
      count      <= '0;
      wbuf       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN;
            byte_cnt   <= '0;
            idx        <= '0;
            count      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
            core_reset <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end

        LEN: begin
          if (accept) begin
            count    <= len_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Equal to capacity is legal because idx carries one extra bit.
              if (len_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state      <= CHECK;
`else
                state      <= DONE;
                done       <= 1'b1;
                core_reset <= 1'b0;
                busy       <= 1'b0;
`endif
              end else if ({1'b0, len_word} > CAPACITY) begin
                state <= ERR;
                error <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end
          end
        end

        DATA: begin
          if (accept) begin
            wbuf     <= {rx_data, wbuf[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            if (byte_cnt == 2'd3) begin
              state      <= WRITE;
              imem_we    <= 1'b1;
              imem_addr  <= BASE_ADDR + 32'({idx, 2'b00});
              imem_wdata <= {rx_data, wbuf};
            end
          end
        end

        WRITE: begin
          imem_we <= 1'b0;
          idx     <= idx + 1'b1;
          if (idx_next == count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= CHECK;
`else
            state      <= DONE;
            done       <= 1'b1;
            core_reset <= 1'b0;
            busy       <= 1'b0;
`endif
          end else begin
            state <= DATA;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            busy <= 1'b0;
            if (rx_data == csum) begin
              state      <= DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader (ADDR_WIDTH=2); define IMEM_LOADER_CHECKSUM_EN to cover the checksum stage.
`timescale 1ns/1ps

module tb_imem_loader;

  localparam int          AW   = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] CAP  = 32'(1 << AW);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       cnt;
    logic [3:0][31:0]  w;
    logic [7:0]        chk_delta;
    int                gap;
    bit                mid_start;
    bit                exp_done;
    bit                exp_err;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          ready_viol = 0;
  logic [63:0] got_w[$];
  logic [63:0] exp_w[$];
  logic [7:0]  stream[$];
  logic        model_done;
  logic        model_err;
  vec_t        vt[$];

  // Every write seen on the memory port, plus any cycle where a byte could be taken during a write.
  always @(negedge clk) begin
    if (imem_we) begin
      got_w.push_back({imem_addr, imem_wdata});
      if (rx_ready) ready_viol++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] cnt, input logic [3:0][31:0] w,
                              input logic [7:0] delta, input int gap, input bit mid,
                              input bit ed, input bit ee);
    vec_t v;
    v.cnt = cnt; v.w = w; v.chk_delta = delta; v.gap = gap;
    v.mid_start = mid; v.exp_done = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; rx_valid = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_rx_ready"},   64'(rx_ready),   64'd0);
    checkOutput({tag, "_imem_we"},    64'(imem_we),    64'd0);
    checkOutput({tag, "_imem_addr"},  64'(imem_addr),  64'd0);
    checkOutput({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    checkOutput({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    checkOutput({tag, "_busy"},       64'(busy),       64'd0);
    checkOutput({tag, "_done"},       64'(done),       64'd0);
    checkOutput({tag, "_error"},      64'(error),      64'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checkOutput("rx_ready_wait", 64'd0, 64'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 rx_valid = 1'b0;
    end
    for (int k = 0; k < gap; k++) @(negedge clk);
  endtask

  // Byte image: LE count, then the payload when the count fits, then the XOR byte when the checksum stage exists.
  task automatic build_stream(input logic [31:0] cnt, input logic [3:0][31:0] w, input logic [7:0] delta);
    logic [7:0] x;
    stream.delete();
    for (int b = 0; b < 4; b++) stream.push_back(cnt[8*b +: 8]);
    if (cnt <= CAP) begin
      x = 8'h00;
      for (int i = 0; i < int'(cnt); i++)
        for (int b = 0; b < 4; b++) begin
          stream.push_back(w[i][8*b +: 8]);
          x ^= w[i][8*b +: 8];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
      stream.push_back(x ^ delta);
`endif
    end
  endtask

  // Derives expected writes and outcome by parsing the byte image directly.
  task automatic model();
    logic [31:0] cnt;
    logic [7:0]  x;
    exp_w.delete();
    cnt = {stream[3], stream[2], stream[1], stream[0]};
    if (cnt > CAP) begin
      model_done = 1'b0; model_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < int'(cnt); i++)
      exp_w.push_back({BASE + 32'(4 * i), stream[4+4*i+3], stream[4+4*i+2], stream[4+4*i+1], stream[4+4*i]});
    for (int j = 0; j < 4 * int'(cnt); j++) x ^= stream[4+j];
`ifdef IMEM_LOADER_CHECKSUM_EN
    model_done = (stream[4 + 4*int'(cnt)] == x);
`else
    model_done = 1'b1;
`endif
    model_err = ~model_done;
  endtask

  task automatic applyStimulus(input int gap, input bit mid_start);
    pulse_start();
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], gap);
      if (mid_start && i == 5) pulse_start();
    end
  endtask

  task automatic run_vector(input string tag, input int gap, input bit mid,
                            input bit exp_done, input bit exp_err);
    int base;
    int n;
    base = got_w.size();
    applyStimulus(gap, mid);
    n = 0;
    while (!(done || error) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_finished"},   64'(done | error), 64'd1);
    checkOutput({tag, "_done"},       64'(done),         64'(exp_done));
    checkOutput({tag, "_error"},      64'(error),        64'(exp_err));
    checkOutput({tag, "_core_reset"}, 64'(core_reset),   64'(!exp_done));
    checkOutput({tag, "_busy"},       64'(busy),         64'd0);
    checkOutput({tag, "_rx_ready"},   64'(rx_ready),     64'd0);
    checkOutput({tag, "_nwrites"},    64'(got_w.size() - base), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && base + i < got_w.size(); i++)
      checkOutput($sformatf("%s_write%0d", tag, i), got_w[base+i], exp_w[i]);
    checkOutput({tag, "_ready_in_write"}, 64'(ready_viol), 64'd0);
  endtask

  initial begin
    int base;
    logic [3:0][31:0] w;
    logic [31:0] cnt;
    logic [7:0]  delta;

    vt.push_back(mk(32'd2, {32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF}, 8'h00, 0, 1'b0, 1'b1, 1'b0));
    vt.push_back(mk(32'd2, {32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF}, 8'h00, 3, 1'b0, 1'b1, 1'b0));
    vt.push_back(mk(32'd5, {32'h0, 32'h0, 32'h0, 32'h0},               8'h00, 0, 1'b0, 1'b0, 1'b1));
    vt.push_back(mk(32'd0, {32'h0, 32'h0, 32'h0, 32'h0},               8'h00, 1, 1'b0, 1'b1, 1'b0));
    vt.push_back(mk(32'd4, {32'hCAFEF00D, 32'h80000000, 32'h0000FFFF, 32'hA5A50001}, 8'h00, 0, 1'b0, 1'b1, 1'b0));
    vt.push_back(mk(32'd1, {32'h0, 32'h0, 32'h0, 32'h44332211},        8'h00, 0, 1'b1, 1'b1, 1'b0));
    vt.push_back(mk(32'd3, {32'h0, 32'h01020304, 32'hFFFFFFFF, 32'h00000000}, 8'h00, 1, 1'b0, 1'b1, 1'b0));
`ifdef IMEM_LOADER_CHECKSUM_EN
    vt.push_back(mk(32'd1, {32'h0, 32'h0, 32'h0, 32'h44332211},        8'h01, 0, 1'b0, 1'b0, 1'b1));
    vt.push_back(mk(32'd0, {32'h0, 32'h0, 32'h0, 32'h0},               8'h01, 0, 1'b0, 1'b0, 1'b1));
`endif

    do_reset();
    check_reset_outputs("reset");

    // Basic load with cycle-exact checks around the final write.
    build_stream(32'd2, {32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF}, 8'h00);
    pulse_start();
    checkOutput("start_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 12; i++) send_byte(stream[i], 0);
    checkOutput("last_write_we",    64'(imem_we),    64'd1);
    checkOutput("last_write_addr",  64'(imem_addr),  64'h4);
    checkOutput("last_write_data",  64'(imem_wdata), 64'h12345678);
    checkOutput("last_write_ready", 64'(rx_ready),   64'd0);
    @(posedge clk); #1;
    checkOutput("after_write_we", 64'(imem_we), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    checkOutput("check_ready", 64'(rx_ready), 64'd1);
    checkOutput("check_done",  64'(done),     64'd0);
    send_byte(stream[12], 0);
`endif
    checkOutput("basic_done",       64'(done),       64'd1);
    checkOutput("basic_core_reset", 64'(core_reset), 64'd0);
    pulse_start();
    checkOutput("restart_core_reset", 64'(core_reset), 64'd1);
    checkOutput("restart_done",       64'(done),       64'd0);
    checkOutput("restart_busy",       64'(busy),       64'd1);

    // Oversized count is rejected the cycle after the 4th length byte.
    do_reset();
    base = got_w.size();
    pulse_start();
    send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    checkOutput("oversize_error",      64'(error),      64'd1);
    checkOutput("oversize_core_reset", 64'(core_reset), 64'd1);
    checkOutput("oversize_busy",       64'(busy),       64'd0);
    checkOutput("oversize_writes",     64'(got_w.size() - base), 64'd0);

    // Reset after 6 payload bytes, then reload from scratch.
    build_stream(32'd2, {32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF}, 8'h00);
    base = got_w.size();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(stream[i], 0);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    check_reset_outputs("midreset");
    repeat (6) @(negedge clk);
    checkOutput("midreset_writes", 64'(got_w.size() - base), 64'd1);
    model();
    run_vector("midreset_reload", 0, 1'b0, model_done, model_err);

    for (int v = 0; v < vt.size(); v++) begin
      build_stream(vt[v].cnt, vt[v].w, vt[v].chk_delta);
      model();
      run_vector($sformatf("vec%0d", v), vt[v].gap, vt[v].mid_start, vt[v].exp_done, vt[v].exp_err);
    end

    for (int r = 0; r < 20; r++) begin
      cnt = 32'($urandom_range(0, 5));
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      build_stream(cnt, w, delta);
      model();
      run_vector($sformatf("rand%0d", r), $urandom_range(0, 2), 1'b0, model_done, model_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory fetch path. Accepts a byte stream from a serial front-end: a 4-byte little-endian word count, then the program image. It assembles little-endian 32-bit words and writes them into instruction memory through a single-cycle write port. The CPU core is held in reset until the image is fully loaded, and released only on success.

Parameters:
ADDR_WIDTH, 10, word-address width of instruction memory; capacity = 2^ADDR_WIDTH words
BASE_ADDR, 32'h0000_0000, byte address of the first image word; word-aligned

Ports:
clk  in  1  single clock; all logic on posedge
reset_n  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins a load session
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader can accept a byte
imem_we  out  1  instruction-memory write enable, one cycle per word
imem_addr  out  32  byte address of the write
imem_wdata  out  32  word to write
core_reset  out  1  active-high reset to the core
busy  out  1  session in progress
done  out  1  sticky; image loaded successfully
error  out  1  sticky; session aborted

Behaviour:
- Interface: single clock clk. reset_n is synchronous and active-low.
- Reset (reset_n=0 at a posedge): state=IDLE. Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, busy=0, done=0, error=0. All counters clear.
- Reset mid-session aborts immediately. No further writes occur, and words already written are not undone.
- Byte handshake: a byte is accepted on a cycle where rx_valid && rx_ready. rx_data is don't-care otherwise.
- rx_ready=1 only in LEN, DATA and CHECK. rx_ready is combinational from state, not from rx_valid.
- States and transitions:
  - IDLE: core_reset=1. On start go to LEN; clear byte counter, word index and done/error.
  - LEN: accept 4 bytes into count[31:0], LSB first. After the 4th byte:
    - count==0 goes to CHECK (feature on) or DONE (feature off).
    - count > 2^ADDR_WIDTH goes to ERR.
    - otherwise go to DATA.
  - DATA: shift bytes into the word buffer LSB first. The 4th accepted byte goes to WRITE the next cycle.
  - WRITE: exactly one cycle with imem_we=1, imem_addr=BASE_ADDR+4*idx, imem_wdata=assembled word, rx_ready=0. Then idx++. If idx+1==count, go to CHECK (feature on) or DONE; else go to DATA.
  - DONE: done=1, core_reset=0, busy=0. start re-enters LEN and reasserts core_reset the cycle after start.
  - ERR: error=1, core_reset=1, busy=0. start re-enters LEN.
- start is ignored in LEN, DATA, WRITE and CHECK.
- busy=1 in LEN, DATA, WRITE and CHECK.
- imem_we is 0 in every state except WRITE. imem_addr and imem_wdata hold their last values outside WRITE.
- Arithmetic: imem_addr is computed in 32 bits and wraps modulo 2^32. idx is ADDR_WIDTH+1 bits, so a full-capacity image (count=2^ADDR_WIDTH) is legal.
- rx_valid stalls (deasserted for any number of cycles) in LEN, DATA or CHECK just hold state. There is no timeout.
- Minimum throughput: one word per 5 cycles (4 byte cycles + 1 WRITE).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: a CHECK state follows the last word, or LEN when count==0.
  - The loader accepts one byte and compares it with the running XOR of all payload bytes; the XOR is 8'h00 for an empty image.
  - Match goes to DONE. Mismatch goes to ERR; words already written remain, and core_reset stays 1.
- Undefined: no CHECK state and no checksum logic. The last WRITE, or count==0, goes directly to DONE.

Test Plan:
- Basic load: reset, start, stream 02 00 00 00, EF BE AD DE, 78 56 34 12. Required response:
  - imem_we pulses twice: addr 0x0 / data 0xDEADBEEF, then addr 0x4 / data 0x12345678.
  - done=1 and core_reset=0 the cycle after the second WRITE (feature off).
- Stalled stream: same image with rx_valid dropped for 3 cycles between every byte. Required response: identical writes; rx_ready never 1 during WRITE; no byte lost or duplicated.
- Oversize: ADDR_WIDTH=2, count bytes 05 00 00 00. Required response: ERR the cycle after the 4th byte; error=1, core_reset=1, zero imem_we pulses.
- Empty image: count 0. Required response:
  - Feature off: DONE with no writes.
  - Feature on: checksum byte 00 gives DONE; checksum byte 01 gives ERR.
- Checksum (feature on): one word 11 22 33 44. Checksum byte 0x44 gives done=1; byte 0x45 gives error=1 after one write of 0x44332211.
- Mid-session reset: reset_n=0 for 1 cycle after 6 payload bytes. Required response:
  - All outputs return to reset values with no further imem_we.
  - A subsequent start and a full stream loads correctly from BASE_ADDR.
